// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: the core-side request/response signals and the
// memory-side request/response signals. The LSU takes the slave view; the
// core and the memory model together take the master view.
//
// Handshakes: a core access is offered by a one-cycle start pulse and is
// accepted only while the LSU is idle. Completion is a one-cycle done pulse
// that carries err and rdata. On the memory side, mem_req is the valid and
// mem_ready is the ready: a transfer completes on the rising edge where both
// are high. mem_addr/mem_we/mem_be/mem_wdata do not change while mem_req is
// waiting, and mem_rdata is only looked at in the cycle where mem_ready is high.
interface load_store_unit_if;
    // core side
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit. An accepted access is checked for legality.
// A legal access becomes a single word-aligned bus transfer with byte
// enables, lane-replicated store data and load-lane extraction. A timeout
// counter aborts a request that the memory never acknowledges. Every output
// is a register.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic        legal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane_d;
    logic [31:0] load_d;

    // Decode the incoming request: legality, byte enables, replicated store data.
    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (bus.is_store)
            legal_d = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal_d = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        // funct3[1:0] is the access size for every legal encoding
        if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
            legal_d = 1'b0;
        if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
            legal_d = 1'b0;
        case (bus.funct3[1:0])
            2'b00:   be_d = 4'b0001 << bus.addr[1:0];
            2'b01:   be_d = 4'b0011 << bus.addr[1:0];
            default: be_d = 4'b1111;
        endcase
        if (bus.is_store) begin
            case (bus.funct3[1:0])
                2'b00:   wdata_d = {4{bus.wdata[7:0]}};
                2'b01:   wdata_d = {2{bus.wdata[15:0]}};
                default: wdata_d = bus.wdata;
            endcase
        end
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        lane_d = bus.mem_rdata >> {addr_lo_q, 3'b000};
        load_d = lane_d;
        case (funct3_q)
            3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b100:  load_d = {24'd0, lane_d[7:0]};
            3'b101:  load_d = {16'd0, lane_d[15:0]};
            default: load_d = lane_d;
        endcase
    end

    // Access sequencer: IDLE accepts, REQ holds the bus, DONE pulses completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        is_store_q <= bus.is_store;
                        funct3_q   <= bus.funct3;
                        addr_lo_q  <= bus.addr[1:0];
                        rdata_q    <= 32'd0;
                        if (!legal_d) begin
                            // illegal accesses never touch the bus
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= 16'd0;
                            busy_q      <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.is_store;
                            mem_addr_q  <= {bus.addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready || cnt_q == TO_LAST) begin
                        // an acknowledge in the last allowed cycle still wins
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= !bus.mem_ready;
                        busy_q      <= 1'b0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_be_q    <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        if (bus.mem_ready && !is_store_q)
                            rdata_q <= load_d;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner accesses, then randomized
// accesses checked against a transaction-level reference model.
module tb_load_store_unit;
    localparam int TO = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [32:0] exp_q[$];   // {err, rdata} expected at each done

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        int f;
        f = int'(f3);
        return f % 4;
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int f;
        int off;
        int sz;
        bit ok;
        f   = int'(f3);
        off = int'(a % 32'd4);
        sz  = size_of(f3);
        ok  = st ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        if (sz == 1 && (off % 2) != 0) ok = 1'b0;
        if (sz == 2 && off != 0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        case (size_of(f3))
            0:       return 4'(1 << off);
            1:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            0:       return (wd & 32'hFF) * 32'h0101_0101;
            1:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] lane;
        logic [31:0] v;
        lane = rd >> (8 * (a % 32'd4));
        case (f3)
            3'b000: begin v = lane & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'b001: begin v = lane & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'b100: v = lane & 32'hFF;
            3'b101: v = lane & 32'hFFFF;
            default: v = lane;
        endcase
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(bus_if.busy),    32'd0);
        check({tag, "_done"},  32'(bus_if.done),    32'd0);
        check({tag, "_req"},   32'(bus_if.mem_req), 32'd0);
        check({tag, "_we"},    32'(bus_if.mem_we),  32'd0);
        check({tag, "_be"},    32'(bus_if.mem_be),  32'd0);
        check({tag, "_wdata"}, bus_if.mem_wdata,    32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        check("rst_err",   32'(bus_if.err),  32'd0);
        check("rst_rdata", bus_if.rdata,     32'd0);
        check("rst_addr",  bus_if.mem_addr,  32'd0);
        rst_n = 1'b1;
    endtask

    // One complete access: waits = REQ cycles with mem_ready low before it rises
    // (waits >= TO means the memory never answers); poke pulses start mid-access.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int waits,
                              input logic [31:0] rd, input bit poke);
        bit          legal;
        bit          finished;
        bit          rdy;
        int          k;
        logic [32:0] exp;
        legal = model_legal(st, f3, a);
        if (!legal)           exp = {1'b1, 32'd0};
        else if (waits >= TO) exp = {1'b1, 32'd0};
        else                  exp = {1'b0, st ? 32'd0 : model_load(f3, a, rd)};
        exp_q.push_back(exp);

        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.is_store = st;
        bus_if.funct3   = f3;
        bus_if.addr     = a;
        bus_if.wdata    = wd;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;

        if (!legal) begin
            exp = exp_q.pop_front();
            check("ill_done", 32'(bus_if.done),    32'd1);
            check("ill_err",  32'(bus_if.err),     32'd1);
            check("ill_req",  32'(bus_if.mem_req), 32'd0);
            check("ill_busy", 32'(bus_if.busy),    32'd0);
        end else begin
            finished = 1'b0;
            k = 0;
            while (!finished && k < TO) begin
                check("req_req",  32'(bus_if.mem_req),  32'd1);
                check("req_busy", 32'(bus_if.busy),     32'd1);
                check("req_done", 32'(bus_if.done),     32'd0);
                check("req_we",   32'(bus_if.mem_we),   32'(st));
                check("req_addr", bus_if.mem_addr,      a & 32'hFFFF_FFFC);
                check("req_be",   32'(bus_if.mem_be),   32'(model_be(f3, a)));
                if (st) check("req_wdata", bus_if.mem_wdata, model_wdata(f3, wd));
                rdy = (k == waits);
                bus_if.mem_ready = rdy;
                bus_if.mem_rdata = rdy ? rd : $urandom;
                if (poke && k == 0) begin
                    bus_if.start    = 1'b1;
                    bus_if.is_store = !st;
                    bus_if.funct3   = 3'($urandom_range(0, 7));
                    bus_if.addr     = $urandom;
                    bus_if.wdata    = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
                bus_if.mem_ready = 1'b0;
                bus_if.start     = 1'b0;
                if (rdy || k == TO - 1) finished = 1'b1;
                k++;
            end
            exp = exp_q.pop_front();
            check("fin_done",  32'(bus_if.done), 32'd1);
            check("fin_err",   32'(bus_if.err),  32'(exp[32]));
            if (!st || exp[32]) check("fin_rdata", bus_if.rdata, exp[31:0]);
            check("fin_busy",  32'(bus_if.busy),      32'd0);
            check("fin_req",   32'(bus_if.mem_req),   32'd0);
            check("fin_we",    32'(bus_if.mem_we),    32'd0);
            check("fin_be",    32'(bus_if.mem_be),    32'd0);
            check("fin_wdata", bus_if.mem_wdata,      32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("post");
        if (legal && (!st || exp[32])) check("post_rdata_hold", bus_if.rdata, exp[31:0]);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus_if.start     = 1'b0;
        bus_if.is_store  = 1'b0;
        bus_if.funct3    = 3'd0;
        bus_if.addr      = 32'd0;
        bus_if.wdata     = 32'd0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;

        apply_reset();

        // LB from the top lane, zero-wait memory
        run_access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234, 1'b0);
        check("lb_rdata_const", bus_if.rdata, 32'hFFFF_FF80);
        // SH to the upper half, three wait cycles
        run_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 3, 32'd0, 1'b0);
        // SB replication and LBU/LH extension
        run_access(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56C3, 1, 32'd0, 1'b0);
        run_access(1'b0, 3'b100, 32'h0000_3001, 32'd0, 0, 32'h0000_C300, 1'b0);
        check("lbu_rdata_const", bus_if.rdata, 32'h0000_00C3);
        run_access(1'b0, 3'b001, 32'h0000_3002, 32'd0, 2, 32'h8001_0000, 1'b0);
        check("lh_rdata_const", bus_if.rdata, 32'hFFFF_8001);
        // misaligned word and reserved funct3
        run_access(1'b0, 3'b010, 32'h0000_0006, 32'd0, 0, 32'd0, 1'b0);
        run_access(1'b0, 3'b011, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0);
        run_access(1'b1, 3'b100, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0);
        // nonzero rdata, then an LHU that times out must clear it
        run_access(1'b0, 3'b010, 32'h0000_0010, 32'd0, 0, 32'h1234_5678, 1'b0);
        check("lw_rdata_const", bus_if.rdata, 32'h1234_5678);
        run_access(1'b0, 3'b101, 32'h0000_0000, 32'd0, 10, 32'd0, 1'b0);
        check("timeout_rdata_const", bus_if.rdata, 32'd0);
        // start while busy is ignored
        run_access(1'b0, 3'b010, 32'h0000_0040, 32'd0, 2, 32'hDEAD_BEEF, 1'b1);
        run_access(1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 0, 32'd0, 1'b1);

        // reset in the middle of a request
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.is_store = 1'b1;
        bus_if.funct3   = 3'b010;
        bus_if.addr     = 32'h0000_0080;
        bus_if.wdata    = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        check("mid_req_up", 32'(bus_if.mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midrst");
        check("midrst_err",   32'(bus_if.err), 32'd0);
        check("midrst_rdata", bus_if.rdata,    32'd0);
        check("midrst_addr",  bus_if.mem_addr, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_done", 32'(bus_if.done),    32'd0);
            check("midrst_no_req",  32'(bus_if.mem_req), 32'd0);
        end

        // randomized accesses
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                       $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
